dec_i2c_mult: RTL

DEC_I2C_MULT -- requirements
Module: dec_i2c_mult

---
 rtl/dec_i2c_mult.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dec_i2c_mult.sv
// I2C slave receiver: matches up to N_END local 7-bit addresses, ACKs and buffers write data in a FIFO.
// Build option: define DEC_I2C_FILTRO_EN to add a 3-sample majority glitch filter on scl/sda.
module dec_i2c_mult #(
   parameter int unsigned N_END = 2,
   parameter int unsigned PROF  = 4,
   localparam int unsigned IW   = (N_END > 1) ? $clog2(N_END) : 1,
   localparam int unsigned AW   = $clog2(PROF),
   localparam int unsigned CW   = AW + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scl,
   input  logic                 sda,
   output logic                 sda_oe,
   input  logic                 pronto,
   input  logic [N_END*7-1:0]   endereco_local,
   output logic [6:0]           endereco_recebido,
   output logic [IW-1:0]        indice_end,
   output logic                 operacao,
   output logic                 ativo,
   output logic                 start,
   output logic                 stop,
   output logic [7:0]           dado,
   output logic                 dado_valido,
   input  logic                 dado_ler,
   output logic [CW-1:0]        contagem,
   output logic                 overflow
);

   localparam logic [CW-1:0] CHEIO = CW'(PROF);

   typedef enum logic [2:0] {
      OCIOSO, ENDERECO, ACK_END, DADO, ACK_DADO, IGNORA
   } estado_t;

   estado_t         estado;
   logic            scl_s1, scl_s2, sda_s1, sda_s2;
   logic            scl_v, sda_v, scl_p, sda_p;
   logic [3:0]      bit_cnt;
   logic [7:0]      sh;
   logic [7:0]      mem [0:PROF-1];
   logic [AW-1:0]   wr_ptr, rd_ptr;

   logic            scl_rise_c, scl_fall_c, start_c, stop_c;
   logic            rx_bit_c, byte_fim_c, push_c, pop_c;
   logic            hit_c;
   logic [IW-1:0]   hit_idx_c;

   // Two-flop synchronizers plus previous-value registers for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         scl_p  <= 1'b1;
         sda_p  <= 1'b1;
      end else begin
         scl_s1 <= scl;
         scl_s2 <= scl_s1;
         sda_s1 <= sda;
         sda_s2 <= sda_s1;
         scl_p  <= scl_v;
         sda_p  <= sda_v;
      end
   end

`ifdef DEC_I2C_FILTRO_EN
   logic [1:0] scl_h, sda_h;

   // Majority of the last three synchronized samples; single-cycle pulses never win
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_h <= 2'b11;
         sda_h <= 2'b11;
         scl_v <= 1'b1;
         sda_v <= 1'b1;
      end else begin
         scl_h <= {scl_h[0], scl_s2};
         sda_h <= {sda_h[0], sda_s2};
         scl_v <= (scl_h[1] & scl_h[0]) | (scl_h[1] & scl_s2) | (scl_h[0] & scl_s2);
         sda_v <= (sda_h[1] & sda_h[0]) | (sda_h[1] & sda_s2) | (sda_h[0] & sda_s2);
      end
   end
`else
   assign scl_v = scl_s2;
   assign sda_v = sda_s2;
`endif

   assign scl_rise_c = scl_v & ~scl_p;
   assign scl_fall_c = ~scl_v & scl_p;
   assign start_c    = scl_v & scl_p & sda_p & ~sda_v;
   assign stop_c     = scl_v & scl_p & ~sda_p & sda_v;

   assign rx_bit_c   = scl_rise_c && (bit_cnt != 4'd8) && ((estado == ENDERECO) || (estado == DADO));
   assign byte_fim_c = scl_fall_c && (bit_cnt == 4'd8);

   assign pop_c  = dado_ler && (contagem != '0);
   assign push_c = (estado == DADO) && byte_fim_c && pronto && ((contagem != CHEIO) || pop_c);

   // Lowest matching index wins: scan downwards so the last hit is the smallest k
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int k = int'(N_END) - 1; k >= 0; k--) begin
         if (endereco_local[7*k +: 7] == endereco_recebido) begin
            hit_c     = 1'b1;
            hit_idx_c = IW'(k);
         end
      end
   end

   // Protocol FSM; START/STOP override whatever byte is in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         estado            <= OCIOSO;
         sda_oe            <= 1'b0;
         ativo             <= 1'b0;
         start             <= 1'b0;
         stop              <= 1'b0;
         overflow          <= 1'b0;
         endereco_recebido <= '0;
         indice_end        <= '0;
         operacao          <= 1'b0;
         bit_cnt           <= '0;
         sh                <= '0;
      end else begin
         start <= start_c;
         stop  <= stop_c;
         if (start_c) begin
            estado  <= ENDERECO;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            ativo   <= 1'b0;
         end else if (stop_c) begin
            estado <= OCIOSO;
            sda_oe <= 1'b0;
            ativo  <= 1'b0;
         end else begin
            if (rx_bit_c) begin
               sh      <= {sh[6:0], sda_v};
               bit_cnt <= bit_cnt + 4'd1;
            end
            case (estado)
               ENDERECO: begin
                  if (rx_bit_c && (bit_cnt == 4'd7)) begin
                     endereco_recebido <= sh[6:0];
                     operacao          <= sda_v;
                  end
                  if (byte_fim_c) begin
                     bit_cnt <= '0;
                     if (hit_c) begin
                        estado     <= ACK_END;
                        sda_oe     <= 1'b1;
                        ativo      <= 1'b1;
                        indice_end <= hit_idx_c;
                     end else begin
                        estado <= IGNORA;
                     end
                  end
               end
               ACK_END: begin
                  if (scl_fall_c) begin
                     sda_oe <= 1'b0;
                     estado <= operacao ? IGNORA : DADO;
                  end
               end
               DADO: begin
                  if (byte_fim_c) begin
                     bit_cnt <= '0;
                     sda_oe  <= push_c;
                     estado  <= ACK_DADO;
                     if (pronto && !push_c) overflow <= 1'b1;
                  end
               end
               ACK_DADO: begin
                  if (scl_fall_c) begin
                     sda_oe <= 1'b0;
                     estado <= DADO;
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

   // FIFO pointers wrap naturally because PROF is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         contagem <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_c, pop_c})
            2'b10:   contagem <= contagem + CW'(1);
            2'b01:   contagem <= contagem - CW'(1);
            default: contagem <= contagem;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= sh;
   end

   assign dado        = mem[rd_ptr];
   assign dado_valido = (contagem != '0);

endmodule
